// File: rtl/gprs_scoreboard_pkg.sv
// Shared constants and types for the GPR file with pending-write scoreboard.
package gprs_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int NREGS_DEF   = 8;
  localparam int NRD_DEF     = 2;
  localparam int MAX_LAT_DEF = 3;

  localparam int AW = $clog2(NREGS_DEF);
  localparam int LW = $clog2(MAX_LAT_DEF + 1);

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [LW-1:0] lat_t;

  // err bit positions
  localparam int ERR_EARLY = 0;
  localparam int ERR_MISS  = 1;

  // Counter width needed to hold 0..max_lat
  function automatic int lat_w(int max_lat);
    return $clog2(max_lat + 1);
  endfunction
endpackage

// File: rtl/gprs_scoreboard_if.sv
// Decode/writeback-facing bus of the register file scoreboard.
interface gprs_scoreboard_if #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 3
);
  localparam int ADDR_W = $clog2(NREGS);
  localparam int LAT_W  = $clog2(MAX_LAT + 1);

  logic [NRD-1:0]                 rd_en;
  logic [NRD-1:0][ADDR_W-1:0]     rd_addr;
  logic [NRD-1:0][DATA_W-1:0]     rd_data;
  logic                           iss_valid;
  logic [ADDR_W-1:0]              iss_dst;
  logic [LAT_W-1:0]               iss_lat;
  logic                           stall;
  logic                           we;
  logic [ADDR_W-1:0]              wa;
  logic [DATA_W-1:0]              wd;
  logic [NREGS-1:0]               pend;
  logic [1:0]                     err;
  logic [NREGS-1:0][DATA_W-1:0]   regfile;

  // CPU side: decode + writeback
  modport master (
    output rd_en, rd_addr, iss_valid, iss_dst, iss_lat, we, wa, wd,
    input  rd_data, stall, pend, err, regfile
  );

  // Register file side
  modport slave (
    input  rd_en, rd_addr, iss_valid, iss_dst, iss_lat, we, wa, wd,
    output rd_data, stall, pend, err, regfile
  );
endinterface

// File: rtl/gprs_sb_counter.sv
// Per-register pending-write countdown. A nonzero count means a writeback is
// outstanding; the count reaches 1 in the cycle the writeback is due.
module gprs_sb_counter
  import gprs_pkg::*;
#(
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             res,
  output logic             cnt_nz,
  output logic             cnt_is1,
  output logic             cnt_gt1,
  output logic             miss
);
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] load_clamp;

  // Latencies beyond the pipeline depth saturate at MAX_LAT
  assign load_clamp = (load_val > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : load_val;

  // Issue reload wins over the free-running decrement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (load)   cnt <= load_clamp;
    else if (cnt_nz) cnt <= cnt - LAT_W'(1);
  end

  assign cnt_nz  = |cnt;
  assign cnt_is1 = (cnt == LAT_W'(1));
  assign cnt_gt1 = cnt_nz && !cnt_is1;
  // Due this cycle but no matching writeback and not being re-issued
  assign miss    = cnt_is1 && !res && !load;
endmodule

// File: rtl/gprs_scoreboard.sv
// Parametrised multi-read register file with pending-write scoreboard:
// RAW/WAW issue stall, write-to-read bypass and sticky protocol errors.
module gprs_scoreboard
  import gprs_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  gprs_scoreboard_if.slave  bus
);
  localparam int ADDR_W = $clog2(NREGS);
  localparam int LAT_W  = lat_w(MAX_LAT);

  logic [NREGS-1:0][DATA_W-1:0] mem;
  logic [NREGS-1:0] res, load, cnt_nz, cnt_is1, cnt_gt1, miss;
  logic raw, waw, stall, accept;

  gprs_sb_counter #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) u_cnt [NREGS-1:0] (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val ({NREGS{bus.iss_lat}}),
    .res      (res),
    .cnt_nz   (cnt_nz),
    .cnt_is1  (cnt_is1),
    .cnt_gt1  (cnt_gt1),
    .miss     (miss)
  );

  // Per-register resolve: the due writeback is arriving right now
  always_comb begin
    res = '0;
    for (int i = 0; i < NREGS; i++)
      res[i] = cnt_is1[i] && bus.we && (bus.wa == ADDR_W'(i));
  end

  // Hazard detection; a resolving writeback clears the hazard same-cycle
  always_comb begin
    raw = 1'b0;
    for (int p = 0; p < NRD; p++)
      if (bus.rd_en[p] && cnt_nz[bus.rd_addr[p]] && !res[bus.rd_addr[p]])
        raw = 1'b1;
    waw    = cnt_nz[bus.iss_dst] && !res[bus.iss_dst];
    stall  = bus.iss_valid && (raw || waw);
    accept = bus.iss_valid && !stall && (|bus.iss_lat);
  end

  // Accepted issue reloads exactly one counter
  always_comb begin
    load = '0;
    for (int i = 0; i < NREGS; i++)
      load[i] = accept && (bus.iss_dst == ADDR_W'(i));
  end

  // Read ports with writeback bypass (independent of rd_en)
  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NRD; p++)
      bus.rd_data[p] = (bus.we && bus.wa == bus.rd_addr[p]) ? bus.wd
                                                            : mem[bus.rd_addr[p]];
  end

  // Register storage; every address is writable, tracked or not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mem <= '0;
    else if (bus.we) mem[bus.wa] <= bus.wd;
  end

  // Sticky protocol errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.err <= '0;
    end else begin
      if (bus.we && cnt_gt1[bus.wa]) bus.err[ERR_EARLY] <= 1'b1;
      if (|miss)                     bus.err[ERR_MISS]  <= 1'b1;
    end
  end

  assign bus.stall   = stall;
  assign bus.pend    = cnt_nz;
  assign bus.regfile = mem;
endmodule

// File: tb/tb_gprs_scoreboard.sv
// Directed bench: the driver queues expected values, the negedge monitor
// pops and compares them against the two DUT configurations.
module tb_gprs_scoreboard;
  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  gprs_scoreboard_if #(.DATA_W(16), .NREGS(8),  .NRD(2), .MAX_LAT(3)) ifa ();
  gprs_scoreboard_if #(.DATA_W(32), .NREGS(16), .NRD(3), .MAX_LAT(5)) ifb ();

  gprs_scoreboard #(.DATA_W(16), .NREGS(8), .NRD(2), .MAX_LAT(3)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa)
  );
  gprs_scoreboard #(.DATA_W(32), .NREGS(16), .NRD(3), .MAX_LAT(5)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    KA_STALL, KA_RD, KA_PEND, KA_ERR, KA_REG, KA_REGOR,
    KB_STALL, KB_RD, KB_PEND, KB_ERR
  } kind_t;

  typedef struct {
    int          cyc;
    kind_t       kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];

  task automatic chk(kind_t k, int idx, logic [63:0] v, string nm);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.idx = idx; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  function automatic logic [63:0] actual(kind_t k, int idx);
    case (k)
      KA_STALL: return 64'(ifa.stall);
      KA_RD:    return 64'(ifa.rd_data[idx]);
      KA_PEND:  return 64'(ifa.pend);
      KA_ERR:   return 64'(ifa.err);
      KA_REG:   return 64'(ifa.regfile[idx]);
      KA_REGOR: return 64'(|ifa.regfile);
      KB_STALL: return 64'(ifb.stall);
      KB_RD:    return 64'(ifb.rd_data[idx]);
      KB_PEND:  return 64'(ifb.pend);
      KB_ERR:   return 64'(ifb.err);
      default:  return '1;
    endcase
  endfunction

  // Monitor: compare everything due this cycle, away from the active edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] a;
      e = q.pop_front();
      a = actual(e.kind, e.idx);
      n_tests++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.rd_en = '0; ifa.rd_addr = '0; ifa.iss_valid = 1'b0; ifa.iss_dst = '0;
    ifa.iss_lat = '0; ifa.we = 1'b0; ifa.wa = '0; ifa.wd = '0;
  endtask

  task automatic idle_b();
    ifb.rd_en = '0; ifb.rd_addr = '0; ifb.iss_valid = 1'b0; ifb.iss_dst = '0;
    ifb.iss_lat = '0; ifb.we = 1'b0; ifb.wa = '0; ifb.wd = '0;
  endtask

  task automatic iss_a(int d, int l);
    ifa.iss_valid = 1'b1; ifa.iss_dst = 3'(d); ifa.iss_lat = 2'(l);
  endtask

  task automatic wr_a(int a, logic [15:0] d);
    ifa.we = 1'b1; ifa.wa = 3'(a); ifa.wd = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_a(); idle_b();
    repeat (2) @(posedge clk);
    #1;
    chk(KA_PEND, 0, 0, "a_rst_pend");
    chk(KA_ERR, 0, 0, "a_rst_err");
    chk(KA_REGOR, 0, 0, "a_rst_regs");
    chk(KB_PEND, 0, 0, "b_rst_pend");
    chk(KB_STALL, 0, 0, "b_rst_stall");
    step(); rst_a = 1'b1; rst_b = 1'b1;

    // Asynchronous reset mid-operation
    step(); idle_a(); iss_a(3, 3); wr_a(3, 16'h1234);
    step(); idle_a(); wr_a(3, 16'h1234);
    chk(KA_PEND, 0, 8'h08, "t1_pend_pre");
    chk(KA_REG, 3, 16'h1234, "t1_reg3_pre");
    step(); idle_a(); rst_a = 1'b0;
    chk(KA_PEND, 0, 0, "t1_pend_async");
    chk(KA_ERR, 0, 0, "t1_err_async");
    chk(KA_REGOR, 0, 0, "t1_regs_async");
    step(); rst_a = 1'b1;

    // RAW stall, then resolve with bypass
    step(); idle_a(); iss_a(2, 2);
    step(); idle_a(); iss_a(6, 0); ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd2;
    chk(KA_STALL, 0, 1, "t2_raw_stall");
    step(); idle_a(); iss_a(6, 0); ifa.rd_en = 2'b01; ifa.rd_addr[0] = 3'd2;
    ifa.rd_addr[1] = 3'd2; wr_a(2, 16'hBEEF);
    chk(KA_STALL, 0, 0, "t2_res_stall");
    chk(KA_RD, 0, 16'hBEEF, "t2_bypass_rd0");
    chk(KA_RD, 1, 16'hBEEF, "t2_bypass_rd1");
    step(); idle_a(); iss_a(0, 0);
    chk(KA_PEND, 0, 0, "t2_pend_clear");
    chk(KA_REG, 2, 16'hBEEF, "t2_reg2");
    chk(KA_ERR, 0, 0, "t2_err");
    step(); idle_a();
    chk(KA_PEND, 0, 0, "t2_lat0_nop");
    chk(KA_RD, 0, 0, "t2_rd_reg0");

    // WAW stall, then accepted issue at the resolving writeback
    step(); idle_a(); iss_a(5, 3);
    step(); idle_a(); iss_a(5, 1);
    chk(KA_STALL, 0, 1, "t3_waw_cnt3");
    chk(KA_PEND, 0, 8'h20, "t3_pend");
    step(); idle_a(); iss_a(5, 1);
    chk(KA_STALL, 0, 1, "t3_waw_cnt2");
    step(); idle_a(); iss_a(5, 1); wr_a(5, 16'h0055);
    chk(KA_STALL, 0, 0, "t3_waw_res");
    step(); idle_a(); wr_a(5, 16'h0056);
    chk(KA_PEND, 0, 8'h20, "t3_reload");
    chk(KA_REG, 5, 16'h0055, "t3_old_written");
    step(); idle_a();
    chk(KA_PEND, 0, 0, "t3_pend_done");
    chk(KA_ERR, 0, 0, "t3_err");
    chk(KA_REG, 5, 16'h0056, "t3_reg5");

    // Early writeback
    step(); idle_a(); iss_a(1, 3);
    step(); idle_a(); wr_a(1, 16'h0007);
    step(); idle_a();
    chk(KA_ERR, 0, 2'b01, "t4_err_early");
    chk(KA_REG, 1, 16'h0007, "t4_reg1");
    step(); rst_a = 1'b0;
    step(); rst_a = 1'b1;

    // Missed writeback
    step(); idle_a(); iss_a(4, 1);
    step(); idle_a();
    chk(KA_PEND, 0, 8'h10, "t5_pend_due");
    chk(KA_ERR, 0, 0, "t5_err_pre");
    step(); idle_a();
    chk(KA_ERR, 0, 2'b10, "t5_err_miss");
    chk(KA_PEND, 0, 0, "t5_pend_clear");

    // Wide configuration: 3-port bypass and latency saturation
    step(); idle_b(); ifb.iss_valid = 1'b1; ifb.iss_dst = 4'd15; ifb.iss_lat = 3'd1;
    step(); idle_b(); ifb.iss_valid = 1'b1; ifb.iss_dst = 4'd0; ifb.iss_lat = 3'd0;
    ifb.rd_en = 3'b111;
    for (int p = 0; p < 3; p++) ifb.rd_addr[p] = 4'd15;
    ifb.we = 1'b1; ifb.wa = 4'd15; ifb.wd = 32'hDEADBEEF;
    chk(KB_STALL, 0, 0, "b_res_stall");
    for (int p = 0; p < 3; p++) chk(KB_RD, p, 32'hDEADBEEF, "b_bypass_rd");
    step(); idle_b(); ifb.iss_valid = 1'b1; ifb.iss_dst = 4'd14; ifb.iss_lat = 3'd7;
    chk(KB_ERR, 0, 0, "b_err_clean");
    chk(KB_PEND, 0, 0, "b_pend_clean");
    step(); idle_b();
    chk(KB_PEND, 0, 16'h4000, "b_sat_pend5");
    repeat (4) step();
    chk(KB_PEND, 0, 16'h4000, "b_sat_pend1");
    step();
    chk(KB_PEND, 0, 0, "b_sat_expired");
    chk(KB_ERR, 0, 2'b10, "b_sat_miss");

    step(); step();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gprs_scoreboard.md
Name: gprs_scoreboard

Overview:
- Parametrised successor to the 8x16 two-read/one-write pipeline register file.
- Generalised in width, register count and read-port count.
- Adds a per-register pending-write scoreboard with hazard stall generation, write-to-read bypass and protocol-error flags.
- Sits between decode (issue/read) and writeback in the pipelined CPU; drives the decode stall.

Parameters:
DATA_W, 16, register data width
NREGS, 8, number of registers (power of 2, >=2)
NRD, 2, number of read ports
MAX_LAT, 3, maximum issue-to-writeback latency in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset; asynchronous and active-low
rd_en  in  NRD  per-port read valid; used for hazard check only
rd_addr  in  NRD*AW  per-port read address
rd_data  out  NRD*DATA_W  per-port read data (combinational, bypassed)
iss_valid  in  1  instruction with register destination requests issue
iss_dst  in  AW  destination register of issuing instruction
iss_lat  in  LW  cycles from issue to expected writeback, 1..MAX_LAT
stall  out  1  issue blocked this cycle (combinational)
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  DATA_W  writeback data
pend  out  NREGS  bit i = register i has a nonzero pending counter
err  out  2  sticky: [0] early writeback, [1] missed writeback
regfile  out  NREGS*DATA_W  all registers, for testbench

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, all counters 0, err=0. pend=0 immediately; stall reflects the combinational equations below.
- Storage: on posedge with we=1, reg[wa] <= wd. Any wa is writable.
- Read: rd_data[p] = wd if (we && wa==rd_addr[p]), else reg[rd_addr[p]]. Bypass is independent of rd_en.
- Counter cnt[i] (LW bits), per register, updated each posedge:
  - Accepted issue (iss_valid && !stall && iss_lat!=0): cnt[iss_dst] <= iss_lat. Issue has priority over the decrement of the same register.
  - Otherwise, if cnt[i]!=0: cnt[i] <= cnt[i]-1.
  - iss_lat=0: no counter change, no error. iss_lat>MAX_LAT: loaded as MAX_LAT.
- Resolve condition: res(i) = (cnt[i]==1 && we && wa==i).
- Stall terms:
  - RAW: any p with rd_en[p] && cnt[rd_addr[p]]!=0 && !res(rd_addr[p]).
  - WAW: iss_valid && cnt[iss_dst]!=0 && !res(iss_dst).
  - stall = iss_valid && (RAW || WAW). Stall is asserted only when iss_valid=1.
- Errors (sticky until reset):
  - err[0] set when we && cnt[wa]>1 (writeback earlier than scheduled). Data is still written.
  - err[1] set when cnt[i]==1 and !res(i), unless an accepted issue reloads register i that cycle.
  - A write with cnt[wa]==0 is an untracked write: legal, no error.
- Simultaneous events:
  - Issue to register r while res(r): accepted. Old value written, new counter loaded.
  - Reads of r in the same cycle see wd through the bypass.
- Latency:
  - Reads: zero cycles.
  - Writes: visible in the register array the next cycle, and same-cycle through the bypass.
  - pend: registered, reflects cnt.

Decomposition:
- Package gprs_pkg:
  - AW=$clog2(NREGS), LW=$clog2(MAX_LAT+1).
  - typedef reg_addr_t, lat_t.
  - err bit index constants ERR_EARLY=0, ERR_MISS=1.
- Sub-module gprs_sb_counter, one per register:
  - Inputs: load, load_val, res.
  - Outputs: cnt_nz, cnt_is1, cnt_gt1, miss.
- Top level: storage array, bypass muxes, stall OR-reduction, err flops.

Test Plan:
- Reset mid-operation: cnt[3]=2, reg[3]=0x1234, then reset=0 -> pend=0, regfile all 0, err=0 immediately (asynchronous), before the next clock edge.
- RAW stall then bypass: issue dst=2 lat=2, next cycle rd_en[0]=1 rd_addr[0]=2 -> stall=1. Following cycle we=1 wa=2 wd=0xBEEF -> stall=0, rd_data[0]=0xBEEF the same cycle, pend[2]=0 after the edge.
- WAW: cnt[5]=3, issue dst=5 lat=1 -> stall=1, cnt[5] unchanged (2 after the edge). When cnt[5]==1 with matching write, the issue is accepted and cnt[5]=1 reloaded.
- Early writeback: issue dst=1 lat=3, next cycle we wa=1 wd=0x0007 -> err=2'b01, reg[1]=0x0007.
- Missed writeback: issue dst=4 lat=1, no write next cycle -> err=2'b10, pend[4]=0.
- Parameter sweep: DATA_W=32, NREGS=16, NRD=3, MAX_LAT=5. Three ports read r15 while cnt[15]=1 and we wa=15 wd=0xDEADBEEF -> stall=0, all rd_data=0xDEADBEEF; iss_lat=7 loads 5.
